bist_full_adder_ctrl: RTL and testbench

BIST controller for the 1-bit full adder circuit under test (CUT): it generates the exhaustive input patterns that drive the CUT's `a`/`b`/`cin` inputs and checks the CUT's `sum`/`cout` responses. Each response is compared against an internal golden full-adder model and the number of failing patterns is counted. The block sits between the test-mode top level and the CUT. The fault-injection controls `f1`/`f2`/`f3` are driven only by the bench, never by this block.

---
 rtl/bist_full_adder_ctrl.sv | 135 +++++++++++++
 tb/tb_bist_full_adder_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_full_adder_ctrl.sv
// BIST controller for a 1-bit full adder CUT: exhaustive pattern generation and response check.
// Optional first-failure capture is built when BIST_FAIL_CAPTURE_EN is defined.
module bist_full_adder_ctrl #(
    parameter int unsigned NUM_PATTERNS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       tpg_a,
    output logic       tpg_b,
    output logic       tpg_cin,
    input  logic       cut_sum,
    input  logic       cut_cout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_count
`ifdef BIST_FAIL_CAPTURE_EN
    ,
    output logic       first_fail_valid,
    output logic [2:0] first_fail_pat,
    output logic [1:0] first_fail_resp
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_PAT = 3'(NUM_PATTERNS - 1);

    state_t     state_q;
    logic [2:0] pat_q;
    logic [2:0] tpg_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [3:0] fail_q;
    logic [3:0] fail_d;
    logic       exp_sum;
    logic       exp_cout;
    logic       mismatch;

`ifdef BIST_FAIL_CAPTURE_EN
    logic       ffv_q;
    logic [2:0] ffpat_q;
    logic [1:0] ffresp_q;
`endif

    // Golden full adder evaluated on the pattern currently driven to the CUT
    always_comb begin
        exp_sum  = pat_q[2] ^ pat_q[1] ^ pat_q[0];
        exp_cout = (pat_q[2] & pat_q[1]) | (pat_q[0] & (pat_q[2] ^ pat_q[1]));
        mismatch = (cut_sum != exp_sum) || (cut_cout != exp_cout);
        fail_d   = fail_q;
        if (mismatch && (fail_q != 4'd8)) begin
            fail_d = fail_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pat_q    <= 3'd0;
            tpg_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 4'd0;
`ifdef BIST_FAIL_CAPTURE_EN
            ffv_q    <= 1'b0;
            ffpat_q  <= 3'd0;
            ffresp_q <= 2'b00;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q  <= RUN;
                        pat_q    <= 3'd0;
                        tpg_q    <= 3'd0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        fail_q   <= 4'd0;
`ifdef BIST_FAIL_CAPTURE_EN
                        ffv_q    <= 1'b0;
                        ffpat_q  <= 3'd0;
                        ffresp_q <= 2'b00;
`endif
                    end
                end
                RUN: begin
                    fail_q <= fail_d;
`ifdef BIST_FAIL_CAPTURE_EN
                    if (mismatch && !ffv_q) begin
                        ffv_q    <= 1'b1;
                        ffpat_q  <= pat_q;
                        ffresp_q <= {cut_sum, cut_cout};
                    end
`endif
                    if (pat_q == LAST_PAT) begin
                        state_q <= DONE;
                        pat_q   <= 3'd0;
                        tpg_q   <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_d == 4'd0);
                    end else begin
                        pat_q <= pat_q + 3'd1;
                        tpg_q <= pat_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {tpg_a, tpg_b, tpg_cin} = tpg_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_q;

`ifdef BIST_FAIL_CAPTURE_EN
    assign first_fail_valid = ffv_q;
    assign first_fail_pat   = ffpat_q;
    assign first_fail_resp  = ffresp_q;
`endif

endmodule

// File: tb/tb_bist_full_adder_ctrl.sv
// Scoreboard bench for bist_full_adder_ctrl with a fault-injectable full adder CUT model.
// Includes a second instance built with NUM_PATTERNS=4.
module tb_bist_full_adder_ctrl;

    localparam int NP = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start4;
    logic f1, f2, f3;

    always #5 clk = ~clk;

    logic       ta, tb, tc, cs, cc, busy, done, pass;
    logic [3:0] fc;
    logic       ta4, tb4, tc4, cs4, cc4, busy4, done4, pass4;
    logic [3:0] fc4;
`ifdef BIST_FAIL_CAPTURE_EN
    logic       ffv, ffv4;
    logic [2:0] ffp, ffp4;
    logic [1:0] ffr, ffr4;
`endif

    // CUT with stuck-at controls; returns {sum, cout}
    function automatic logic [1:0] cut_fn(input logic [2:0] p, input logic g1,
                                          input logic g2, input logic g3);
        logic a, b, c, s, co;
        a  = p[2] & g1;
        b  = p[1];
        c  = p[0];
        s  = g3 ? 1'b1 : (a ^ b ^ c);
        co = (a & b & g2) | (c & (a ^ b));
        return {s, co};
    endfunction

    assign {cs, cc}   = cut_fn({ta, tb, tc}, f1, f2, f3);
    assign {cs4, cc4} = cut_fn({ta4, tb4, tc4}, 1'b1, 1'b1, 1'b0);

    bist_full_adder_ctrl #(.NUM_PATTERNS(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .tpg_a(ta), .tpg_b(tb), .tpg_cin(tc),
        .cut_sum(cs), .cut_cout(cc),
        .busy(busy), .done(done), .pass(pass), .fail_count(fc)
`ifdef BIST_FAIL_CAPTURE_EN
        , .first_fail_valid(ffv), .first_fail_pat(ffp), .first_fail_resp(ffr)
`endif
    );

    bist_full_adder_ctrl #(.NUM_PATTERNS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .tpg_a(ta4), .tpg_b(tb4), .tpg_cin(tc4),
        .cut_sum(cs4), .cut_cout(cc4),
        .busy(busy4), .done(done4), .pass(pass4), .fail_count(fc4)
`ifdef BIST_FAIL_CAPTURE_EN
        , .first_fail_valid(ffv4), .first_fail_pat(ffp4), .first_fail_resp(ffr4)
`endif
    );

    typedef struct {
        int         fails;
        bit         ps;
        bit         ffv;
        logic [2:0] fp;
        logic [1:0] fr;
        int         sc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: golden adder as integer addition, versus faulted CUT
    function automatic exp_t model(input logic g1, input logic g2, input logic g3,
                                   input int sc);
        exp_t e;
        e.fails = 0;
        e.ffv   = 1'b0;
        e.fp    = 3'd0;
        e.fr    = 2'd0;
        e.sc    = sc;
        for (int p = 0; p < NP; p++) begin
            int v;
            logic [1:0] gold;
            logic [1:0] r;
            v    = ((p >> 2) & 1) + ((p >> 1) & 1) + (p & 1);
            gold = {1'(v % 2), 1'(v / 2)};
            r    = cut_fn(3'(p), g1, g2, g3);
            if (r != gold) begin
                e.fails++;
                if (!e.ffv) begin
                    e.ffv = 1'b1;
                    e.fp  = 3'(p);
                    e.fr  = r;
                end
            end
        end
        e.ps = (e.fails == 0);
        return e;
    endfunction

    // Monitor: pops the scoreboard on each completed run
    logic done_d = 1'b0;
    int busy_len = 0;
    always @(negedge clk) begin
        exp_t e;
        chk("busy_done_excl", int'(busy && done), 0);
        if (rst) busy_len = 0;
        else if (busy) busy_len++;
        if (done && !done_d) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc - e.sc, NP);
                chk("busy_len", busy_len, NP);
                chk("fail_count", int'(fc), e.fails);
                chk("pass", int'(pass), int'(e.ps));
`ifdef BIST_FAIL_CAPTURE_EN
                chk("ff_valid", int'(ffv), int'(e.ffv));
                if (e.ffv) begin
                    chk("ff_pat", int'(ffp), int'(e.fp));
                    chk("ff_resp", int'(ffr), int'(e.fr));
                end
`endif
            end
            busy_len = 0;
        end
        done_d = done;
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_once(input logic g1, input logic g2, input logic g3);
        @(negedge clk);
        f1 = g1;
        f2 = g2;
        f3 = g3;
        start = 1'b1;
        q.push_back(model(g1, g2, g3, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    function automatic int all_outs();
        int v;
        v = int'({ta, tb, tc, busy, done, pass, fc});
`ifdef BIST_FAIL_CAPTURE_EN
        v = v | int'({ffv, ffp, ffr}) << 16;
`endif
        return v;
    endfunction

    initial begin
        int s0;
        int n;
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        f1 = 1'b1;
        f2 = 1'b1;
        f3 = 1'b0;
        #12;
        chk("reset_outs", all_outs(), 0);
        @(negedge clk);
        rst = 1'b0;

        run_once(1'b1, 1'b1, 1'b0);
        run_once(1'b0, 1'b1, 1'b0);
        run_once(1'b1, 1'b1, 1'b1);
        run_once(1'b1, 1'b0, 1'b0);

        // start held through a run and into DONE: exactly two runs
        @(negedge clk);
        f1 = 1'b0;
        f2 = 1'b1;
        f3 = 1'b0;
        start = 1'b1;
        s0 = cyc + 1;
        q.push_back(model(1'b0, 1'b1, 1'b0, s0));
        repeat (9) @(negedge clk);
        f1 = 1'b1;
        q.push_back(model(1'b1, 1'b1, 1'b0, s0 + 9));
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset in the middle of a faulty run
        @(negedge clk);
        f1 = 1'b0;
        start = 1'b1;
        q.push_back(model(1'b0, 1'b1, 1'b0, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({ta, tb, tc} != 3'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pat3", int'({ta, tb, tc}), 3);
        rst = 1'b1;
        q.delete();
        #1;
        chk("midrun_reset_outs", all_outs(), 0);
        @(negedge clk);
        chk("held_reset_outs", all_outs(), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", all_outs(), 0);
        run_once(1'b1, 1'b1, 1'b0);

        repeat (12) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_once(1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reduced pattern count instance
        @(negedge clk);
        start4 = 1'b1;
        s0 = cyc + 1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 40) begin
            if ({ta4, tb4, tc4} > 3'd3) chk("np4_tpg_range", int'({ta4, tb4, tc4}), 3);
            @(negedge clk);
            n++;
        end
        chk("np4_done", int'(done4), 1);
        chk("np4_latency", cyc - s0, 4);
        chk("np4_pass", int'(pass4), 1);
        chk("np4_fail_count", int'(fc4), 0);
        chk("np4_busy", int'(busy4), 0);

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
